// File: rtl/game_pkg.sv
// Shared key constants and conditioner state type for the pet game pipeline.
package game_pkg;

  localparam logic [7:0] KEY_NONE = 8'h00;
  localparam logic [7:0] KEY_Q    = 8'h14;
  localparam logic [7:0] KEY_W    = 8'h1A;
  localparam logic [7:0] KEY_S    = 8'h16;

  typedef enum logic [1:0] {IDLE, ARM, HOLD, REL} keycond_state_t;

  function automatic logic is_game_key(input logic [7:0] code);
    return (code == KEY_Q) || (code == KEY_W) || (code == KEY_S);
  endfunction

endpackage

// File: rtl/key_conditioner_sync_edge.sv
// Two-flop synchroniser followed by a rising-edge detector for VGA-domain strobes.
module sync_edge (
  input  logic Clk,
  input  logic Reset_n,
  input  logic async_in,
  output logic pulse
);

  logic [2:0] sh;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) sh <= '0;
    else          sh <= {sh[1:0], async_in};
  end

  // sh[1] is the synchronised level, sh[2] its one-cycle-old copy
  assign pulse = sh[1] & ~sh[2];

endmodule

// File: rtl/key_conditioner.sv
// Filters, debounces and frame-aligns USB game keys into one clean event per press.
module key_conditioner
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned HOLD_FRAMES     = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  output logic [7:0] key,
  output logic       key_valid,
  output logic       dropped
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned HW = $clog2(HOLD_FRAMES) + 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);

  logic [7:0]    filt, cand, stable, code, code_n, key_n;
  logic [CW-1:0] cnt;
  logic [HW-1:0] hcnt, hcnt_n;
  logic          st_new, tick, valid_n, drop_n, new_other;
  keycond_state_t state, state_n;

  assign filt = is_game_key(keycode) ? keycode : KEY_NONE;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cand   <= KEY_NONE;
      cnt    <= '0;
      stable <= KEY_NONE;
      st_new <= 1'b0;
    end else if (filt != cand) begin
      cand   <= filt;
      cnt    <= '0;
      st_new <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      stable <= cand;
      st_new <= (cand != stable);
    end else begin
      cnt    <= cnt + 1'b1;
      st_new <= 1'b0;
    end
  end

  sync_edge u_frame_tick (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .async_in (frame_clk),
    .pulse    (tick)
  );

  // a debounced change to some other game key than the one latched
  assign new_other = st_new && (stable != KEY_NONE) && (stable != code);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      code      <= KEY_NONE;
      hcnt      <= '0;
      key       <= KEY_NONE;
      key_valid <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      state     <= state_n;
      code      <= code_n;
      hcnt      <= hcnt_n;
      key       <= key_n;
      key_valid <= valid_n;
      dropped   <= drop_n;
    end
  end

  always_comb begin
    state_n = state;
    code_n  = code;
    hcnt_n  = hcnt;
    key_n   = key;
    valid_n = key_valid;
    drop_n  = 1'b0;
    case (state)
      IDLE: begin
        key_n   = KEY_NONE;
        valid_n = 1'b0;
        if (st_new && stable != KEY_NONE) begin
          state_n = ARM;
          code_n  = stable;
        end
      end
      ARM: begin
        drop_n = new_other;
        if (tick) begin
          state_n = HOLD;
          key_n   = code;
          valid_n = 1'b1;
          hcnt_n  = '0;
        end
      end
      HOLD: begin
        drop_n = new_other;
        if (tick) begin
          if (hcnt == HOLD_LAST) begin
            state_n = REL;
            key_n   = KEY_NONE;
            valid_n = 1'b0;
          end else begin
            hcnt_n = hcnt + 1'b1;
          end
        end
      end
      REL: begin
        if (stable == KEY_NONE) begin
          state_n = IDLE;
        end else if (new_other) begin
          state_n = ARM;
          code_n  = stable;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Upstream stage of the pet game FSM.
- Takes the raw USB keycode from the NIOS PIO (Clk domain) and filters it to the game keys Q/W/S.
- Debounces the filtered code and turns each press into one clean key event.
- Holds that event for a fixed number of whole frame_clk periods, so the frame-rate game FSM samples it exactly once per press, then returns 0x00 until the key is released.

Parameters:
- DEBOUNCE_CYCLES, 50000: Clk cycles the filtered keycode must stay unchanged before it is accepted (1 ms at 50 MHz); legal minimum 1.
- HOLD_FRAMES, 2: number of frame ticks the event is presented on key. 2 guarantees one sample by a consumer that advances every other frame.

Ports:
- Clk  in  1: 50 MHz system clock.
- Reset_n  in  1: asynchronous, active-low reset.
- frame_clk  in  1: VGA vertical sync; asynchronous to Clk.
- keycode  in  8: raw USB keycode, 0x00 = no key.
- key  out  8: conditioned key to the game FSM; 0x00 when no event.
- key_valid  out  1: high exactly while key is non-zero (state HOLD).
- dropped  out  1: one-Clk pulse when an accepted press is discarded.

Behaviour:
- Reset (Reset_n low, asynchronous, any time including mid-HOLD):
  - state = IDLE; key = 0x00, key_valid = 0, dropped = 0.
  - Debounce candidate, stable code, counter, hold counter and sync flops all cleared.
- Filter: filt = keycode if keycode ∈ {KEY_Q 0x14, KEY_W 0x1A, KEY_S 0x16}, else 0x00.
- Debounce:
  - Registers cand, cnt, stable.
  - If filt != cand: cand <= filt, cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= cand; cnt saturates there.
  - Else cnt <= cnt+1.
  - Latency from a steady input change to stable update = DEBOUNCE_CYCLES+1 Clk.
  - Any glitch shorter than DEBOUNCE_CYCLES leaves stable unchanged.
  - st_new = 1-cycle pulse when stable changes value.
- Frame tick:
  - frame_clk passes through a 2-flop synchroniser, then rising-edge detect.
  - tick = 1-Clk pulse, 3 Clk after a frame_clk rise.
- FSM, registered outputs, all transitions on posedge Clk:
  - IDLE: key = 0x00. On st_new with stable != 0 -> ARM, latch code <= stable. A tick in the same cycle is not consumed.
  - ARM: key = 0x00; waits for the next tick so key changes just after a frame edge.
    - On tick -> HOLD, key <= code, key_valid <= 1, hcnt <= 0.
    - If stable returns to 0 before the tick (debounced release), the press is still delivered: stay in ARM.
    - If stable changes to a different nonzero code: keep the old code, pulse dropped.
  - HOLD: key = code. On each tick hcnt <= hcnt+1. On the tick where hcnt == HOLD_FRAMES-1 -> REL, key <= 0x00, key_valid <= 0.
    - A key is therefore held for exactly HOLD_FRAMES full frame periods.
    - A new different nonzero stable code during HOLD: pulse dropped, ignored.
  - REL: key = 0x00; no auto-repeat.
    - stable == 0 -> IDLE.
    - st_new with a different nonzero stable code (roll-over without release) -> ARM with the new code.
    - Same key still held: stay.
- dropped is asserted only in ARM/HOLD, for one cycle per discarded stable change.
- Width rules:
  - cnt is $clog2(DEBOUNCE_CYCLES)+1 bits, saturating, never wraps.
  - hcnt is $clog2(HOLD_FRAMES)+1 bits, reset on HOLD entry.

Decomposition:
- Package game_pkg:
  - KEY_NONE = 0x00, KEY_Q = 0x14, KEY_W = 0x1A, KEY_S = 0x16.
  - typedef enum logic [1:0] {IDLE, ARM, HOLD, REL} keycond_state_t.
  - The game FSM imports the same key constants.
- Sub-module sync_edge: 2-flop synchroniser plus rising-edge pulse (Clk, Reset_n, async_in -> pulse). Reused for other VGA-domain strobes.

Test Plan (bench uses DEBOUNCE_CYCLES=4, HOLD_FRAMES=2, frame_clk period 40 Clk):
- Reset: drive Reset_n=0 mid-HOLD with key=0x14 -> key=0x00 and key_valid=0 immediately (asynchronous); after release, FSM is in IDLE.
- Clean press: keycode=0x14 steady for 200 Clk -> stable at 0x14 after 5 Clk. key=0x14 from 3 Clk after the next frame_clk rise, for exactly 80 Clk (2 ticks), then 0x00; no second event while held.
- Glitch and filter: keycode=0x1A for 3 Clk then 0x00 -> key stays 0x00. keycode=0x04 ('A') held for 100 Clk -> key stays 0x00.
- Roll-over: 0x14 held until REL, then 0x1A without passing through 0x00 -> second event key=0x1A, held for 2 ticks.
- Conflict: 0x14 press, then 0x16 becomes stable during HOLD -> dropped pulses once, key stays 0x14 for the full hold, and the 0x16 event follows only via REL/roll-over.
- Short press: 0x16 stable for 10 Clk, released before any tick -> key=0x16 is still presented for 2 ticks, then IDLE.
